// File: rtl/aoi22_fault_coverage_collector_pkg.sv
// Shared constants, FSM state encoding and helpers for the AOI22 fault coverage collector.
package aoi22_fault_coverage_collector_pkg;

    localparam int NUM_NETS    = 8;
    localparam int NUM_FAULTS  = 16;
    localparam int PAT_W       = 4;
    localparam int FAULT_IDX_W = 4;
    localparam int COUNT_W     = 5;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE        = 3'd0;
    localparam state_t ST_APPLY       = 3'd1;
    localparam state_t ST_SETTLE_WAIT = 3'd2;
    localparam state_t ST_CAPTURE     = 3'd3;
    localparam state_t ST_FINISH      = 3'd4;

    function automatic logic [COUNT_W-1:0] popcount16(input logic [NUM_FAULTS-1:0] v);
        logic [COUNT_W-1:0] c;
        c = 5'd0;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/aoi22_fault_coverage_collector_if.sv
// Pattern/detect/query bundle between the collector and the external fault simulator.
interface aoi22_fault_coverage_collector_if;
    import aoi22_fault_coverage_collector_pkg::*;

    logic                   start;
    logic [NUM_NETS-1:0]    detect_sa0;
    logic [NUM_NETS-1:0]    detect_sa1;
    logic [FAULT_IDX_W-1:0] query_idx;
    logic                   pat_a;
    logic                   pat_b;
    logic                   pat_c;
    logic                   pat_d;
    logic                   busy;
    logic                   done;
    logic [NUM_NETS-1:0]    covered_sa0;
    logic [NUM_NETS-1:0]    covered_sa1;
    logic [COUNT_W-1:0]     cov_count;
    logic [NUM_FAULTS-1:0]  pat_useful;
    logic [PAT_W-1:0]       first_pat;
    logic                   first_valid;

    modport master (
        output start, detect_sa0, detect_sa1, query_idx,
        input  pat_a, pat_b, pat_c, pat_d, busy, done, covered_sa0, covered_sa1,
               cov_count, pat_useful, first_pat, first_valid
    );

    modport slave (
        input  start, detect_sa0, detect_sa1, query_idx,
        output pat_a, pat_b, pat_c, pat_d, busy, done, covered_sa0, covered_sa1,
               cov_count, pat_useful, first_pat, first_valid
    );

endinterface

// File: rtl/aoi22_fault_coverage_collector_fault_first_detect_table.sv
// Per-fault record of the first pattern that detected it; entries are write-once until cleared.
module fault_first_detect_table
    import aoi22_fault_coverage_collector_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [NUM_FAULTS-1:0]  new_mask,
    input  logic [PAT_W-1:0]       pattern,
    input  logic [FAULT_IDX_W-1:0] query_idx,
    output logic [PAT_W-1:0]       first_pat,
    output logic                   first_valid
);

    logic [PAT_W-1:0]      entry_r [NUM_FAULTS];
    logic [NUM_FAULTS-1:0] valid_r;

    // Record the current pattern for faults seen for the first time.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid_r <= {NUM_FAULTS{1'b0}};
            for (int i = 0; i < NUM_FAULTS; i++) begin
                entry_r[i] <= {PAT_W{1'b0}};
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_FAULTS; i++) begin
                if (new_mask[i] && !valid_r[i]) begin
                    entry_r[i] <= pattern;
                    valid_r[i] <= 1'b1;
                end
            end
        end
    end

    // Combinational lookup; an unrecorded fault reads back as pattern 0.
    always_comb begin
        first_valid = valid_r[query_idx];
        if (valid_r[query_idx]) begin
            first_pat = entry_r[query_idx];
        end else begin
            first_pat = {PAT_W{1'b0}};
        end
    end

endmodule

// File: rtl/aoi22_fault_coverage_collector.sv
// Sweeps test patterns into an external AOI22 fault simulator and accumulates sticky coverage.
module aoi22_fault_coverage_collector
    import aoi22_fault_coverage_collector_pkg::*;
#(
    parameter int PAT_LAST = 15,
    parameter int SETTLE   = 1
)
(
    input  logic                            clk,
    input  logic                            rst,
    aoi22_fault_coverage_collector_if.slave bus
);

    localparam logic [PAT_W-1:0] PAT_LAST_V  = PAT_W'(PAT_LAST);
    localparam logic [1:0]       SETTLE_LAST = 2'(SETTLE - 1);

    state_t                state_r;
    logic [PAT_W-1:0]      pattern_r;
    logic [1:0]            settle_cnt_r;
    logic [NUM_NETS-1:0]   covered_sa0_r;
    logic [NUM_NETS-1:0]   covered_sa1_r;
    logic [COUNT_W-1:0]    cov_count_r;
    logic [NUM_FAULTS-1:0] pat_useful_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  launch_s;
    logic                  capture_s;
    logic [NUM_NETS-1:0]   new_sa0_s;
    logic [NUM_NETS-1:0]   new_sa1_s;
    logic [NUM_FAULTS-1:0] merged_s;

    // New-fault detection against the sticky masks, and START qualification.
    always_comb begin
        launch_s  = bus.start && ((state_r == ST_IDLE) || (state_r == ST_FINISH));
        capture_s = (state_r == ST_CAPTURE);
        new_sa0_s = bus.detect_sa0 & ~covered_sa0_r;
        new_sa1_s = bus.detect_sa1 & ~covered_sa1_r;
        merged_s  = {covered_sa1_r | bus.detect_sa1, covered_sa0_r | bus.detect_sa0};
    end

    // Sweep sequencer and coverage accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pattern_r     <= {PAT_W{1'b0}};
            settle_cnt_r  <= 2'd0;
            covered_sa0_r <= {NUM_NETS{1'b0}};
            covered_sa1_r <= {NUM_NETS{1'b0}};
            cov_count_r   <= {COUNT_W{1'b0}};
            pat_useful_r  <= {NUM_FAULTS{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_FINISH: begin
                    if (bus.start) begin
                        state_r       <= ST_APPLY;
                        pattern_r     <= {PAT_W{1'b0}};
                        covered_sa0_r <= {NUM_NETS{1'b0}};
                        covered_sa1_r <= {NUM_NETS{1'b0}};
                        cov_count_r   <= {COUNT_W{1'b0}};
                        pat_useful_r  <= {NUM_FAULTS{1'b0}};
                        busy_r        <= 1'b1;
                        done_r        <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    settle_cnt_r <= 2'd1;
                    state_r      <= (SETTLE_LAST == 2'd0) ? ST_CAPTURE : ST_SETTLE_WAIT;
                end
                ST_SETTLE_WAIT: begin
                    if (settle_cnt_r >= SETTLE_LAST) begin
                        state_r <= ST_CAPTURE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 2'd1;
                    end
                end
                ST_CAPTURE: begin
                    covered_sa0_r <= merged_s[NUM_NETS-1:0];
                    covered_sa1_r <= merged_s[NUM_FAULTS-1:NUM_NETS];
                    cov_count_r   <= popcount16(merged_s);
                    if ((new_sa0_s != 8'h00) || (new_sa1_s != 8'h00)) begin
                        pat_useful_r[pattern_r] <= 1'b1;
                    end
                    // Stop on the last pattern rather than wrapping back to 0.
                    if (pattern_r < PAT_LAST_V) begin
                        pattern_r <= pattern_r + 4'd1;
                        state_r   <= ST_APPLY;
                    end else begin
                        state_r <= ST_FINISH;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    fault_first_detect_table u_table (
        .clk         (clk),
        .rst         (rst),
        .clr         (launch_s),
        .wr_en       (capture_s),
        .new_mask    ({new_sa1_s, new_sa0_s}),
        .pattern     (pattern_r),
        .query_idx   (bus.query_idx),
        .first_pat   (bus.first_pat),
        .first_valid (bus.first_valid)
    );

    assign bus.pat_a       = pattern_r[3];
    assign bus.pat_b       = pattern_r[2];
    assign bus.pat_c       = pattern_r[1];
    assign bus.pat_d       = pattern_r[0];
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.covered_sa0 = covered_sa0_r;
    assign bus.covered_sa1 = covered_sa1_r;
    assign bus.cov_count   = cov_count_r;
    assign bus.pat_useful  = pat_useful_r;

endmodule

// File: tb/tb_aoi22_fault_coverage_collector.sv
// Scoreboard bench: an AOI22 stuck-at simulator (nets 0=Y 1..4=A..D 5=AB 6=CD 7=OR) feeds two collectors.
module tb_aoi22_fault_coverage_collector;
    import aoi22_fault_coverage_collector_pkg::*;

    localparam int K_BUSY = 0, K_DONE = 1, K_COUNT = 2, K_SA0 = 3, K_SA1 = 4;
    localparam int K_USEFUL = 5, K_FPAT = 6, K_FVALID = 7, K_PAT = 8;

    typedef struct {
        int          dut;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic use_stub;
    logic [15:0] det0;
    logic [15:0] det1;
    exp_t sb_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    // Hand-derived first-detect pattern for each fault index (0..7 s-a-0, 8..15 s-a-1).
    logic [3:0] real_first [16] = '{4'd0, 4'd12, 4'd12, 4'd3, 4'd3, 4'd12, 4'd3, 4'd3,
                                    4'd3, 4'd4,  4'd8,  4'd1, 4'd2, 4'd0,  4'd0, 4'd0};

    always #5 clk = ~clk;

    aoi22_fault_coverage_collector_if bus0 ();
    aoi22_fault_coverage_collector_if bus1 ();

    aoi22_fault_coverage_collector dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    aoi22_fault_coverage_collector #(.PAT_LAST(3), .SETTLE(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    function automatic logic aoi_eval(input logic [3:0] p, input int net, input logic val, input logic inj);
        logic a, b, c, d, ab, cd, o, y;
        a  = (inj && net == 1) ? val : p[3];
        b  = (inj && net == 2) ? val : p[2];
        c  = (inj && net == 3) ? val : p[1];
        d  = (inj && net == 4) ? val : p[0];
        ab = (inj && net == 5) ? val : (a & b);
        cd = (inj && net == 6) ? val : (c & d);
        o  = (inj && net == 7) ? val : (ab | cd);
        y  = (inj && net == 0) ? val : ~o;
        return y;
    endfunction

    function automatic logic [15:0] aoi_detect(input logic [3:0] p);
        logic good;
        logic [15:0] d;
        good = aoi_eval(p, 0, 1'b0, 1'b0);
        for (int n = 0; n < 8; n++) begin
            d[n]     = aoi_eval(p, n, 1'b0, 1'b1) != good;
            d[n + 8] = aoi_eval(p, n, 1'b1, 1'b1) != good;
        end
        return d;
    endfunction

    always_comb begin
        det0 = aoi_detect({bus0.pat_a, bus0.pat_b, bus0.pat_c, bus0.pat_d});
        det1 = aoi_detect({bus1.pat_a, bus1.pat_b, bus1.pat_c, bus1.pat_d});
        if (use_stub) begin
            bus0.detect_sa0 = ({bus0.pat_a, bus0.pat_b, bus0.pat_c, bus0.pat_d} == 4'd5) ? 8'h01 : 8'h00;
            bus0.detect_sa1 = 8'h00;
        end else begin
            bus0.detect_sa0 = det0[7:0];
            bus0.detect_sa1 = det0[15:8];
        end
        bus1.detect_sa0 = det1[7:0];
        bus1.detect_sa1 = det1[15:8];
    end

    function automatic logic [31:0] actual(input int dut, input int kind);
        case (kind)
            K_BUSY:   return (dut == 1) ? 32'(bus1.busy)        : 32'(bus0.busy);
            K_DONE:   return (dut == 1) ? 32'(bus1.done)        : 32'(bus0.done);
            K_COUNT:  return (dut == 1) ? 32'(bus1.cov_count)   : 32'(bus0.cov_count);
            K_SA0:    return (dut == 1) ? 32'(bus1.covered_sa0) : 32'(bus0.covered_sa0);
            K_SA1:    return (dut == 1) ? 32'(bus1.covered_sa1) : 32'(bus0.covered_sa1);
            K_USEFUL: return (dut == 1) ? 32'(bus1.pat_useful)  : 32'(bus0.pat_useful);
            K_FPAT:   return (dut == 1) ? 32'(bus1.first_pat)   : 32'(bus0.first_pat);
            K_FVALID: return (dut == 1) ? 32'(bus1.first_valid) : 32'(bus0.first_valid);
            K_PAT:    return (dut == 1) ? 32'({bus1.pat_a, bus1.pat_b, bus1.pat_c, bus1.pat_d})
                                        : 32'({bus0.pat_a, bus0.pat_b, bus0.pat_c, bus0.pat_d});
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_BUSY:   return "busy";
            K_DONE:   return "done";
            K_COUNT:  return "cov_count";
            K_SA0:    return "covered_sa0";
            K_SA1:    return "covered_sa1";
            K_USEFUL: return "pat_useful";
            K_FPAT:   return "first_pat";
            K_FVALID: return "first_valid";
            K_PAT:    return "pattern";
            default:  return "unknown";
        endcase
    endfunction

    // Monitor: pops queued expectations and compares on the falling edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = sb_q.pop_front();
            act = actual(e.dut, e.kind);
            n_cmp++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s dut%0d q=%0d: got %0h, required %0h", kname(e.kind), e.dut,
                         (e.dut == 1) ? bus1.query_idx : bus0.query_idx, act, e.exp);
            end
        end
    end

    task automatic expect_v(input int dut, input int kind, input logic [31:0] v);
        exp_t e;
        e.dut  = dut;
        e.kind = kind;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic check_now(input int dut, input int kind, input logic [31:0] v);
        logic [31:0] act;
        act = actual(dut, kind);
        n_cmp++;
        if (act !== v) begin
            n_fail++;
            $display("FAIL (immediate) %s dut%0d: got %0h, required %0h", kname(kind), dut, act, v);
        end
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int dut);
        if (dut == 1) bus1.start = 1'b1; else bus0.start = 1'b1;
        tick(1);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic expect_query(input int dut, input int idx, input logic [3:0] fpat, input logic fvalid);
        if (dut == 1) bus1.query_idx = 4'(idx); else bus0.query_idx = 4'(idx);
        #1;
        expect_v(dut, K_FPAT, 32'(fpat));
        expect_v(dut, K_FVALID, 32'(fvalid));
        drain();
    endtask

    task automatic expect_result(input int dut, input logic [4:0] cnt, input logic [7:0] sa0,
                                 input logic [7:0] sa1, input logic [15:0] useful);
        expect_v(dut, K_DONE, 32'd1);
        expect_v(dut, K_BUSY, 32'd0);
        expect_v(dut, K_COUNT, 32'(cnt));
        expect_v(dut, K_SA0, 32'(sa0));
        expect_v(dut, K_SA1, 32'(sa1));
        expect_v(dut, K_USEFUL, 32'(useful));
        drain();
    endtask

    initial begin
        rst = 1'b1;
        use_stub = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        bus0.query_idx = 4'd0;
        bus1.query_idx = 4'd0;
        tick(2);
        check_now(0, K_BUSY, 32'd0);
        check_now(0, K_DONE, 32'd0);
        check_now(0, K_COUNT, 32'd0);
        check_now(0, K_SA0, 32'd0);
        check_now(0, K_SA1, 32'd0);
        check_now(0, K_USEFUL, 32'd0);
        check_now(0, K_FVALID, 32'd0);
        check_now(0, K_PAT, 32'd0);
        check_now(1, K_DONE, 32'd0);
        drain();
        rst = 1'b0;
        tick(1);

        // Full sweep with the real simulator: DONE exactly 32 cycles after START.
        pulse_start(0);
        tick(31);
        expect_v(0, K_DONE, 32'd0);
        expect_v(0, K_BUSY, 32'd1);
        drain();
        tick(1);
        check_now(0, K_DONE, 32'd1);
        expect_v(0, K_PAT, 32'd15);
        expect_result(0, 5'd16, 8'hFF, 8'hFF, 16'h111F);
        for (int i = 0; i < 16; i++) begin
            expect_query(0, i, real_first[i], 1'b1);
        end

        // A second START mid-sweep is ignored.
        pulse_start(0);
        tick(6);
        pulse_start(0);
        tick(24);
        expect_v(0, K_DONE, 32'd0);
        expect_v(0, K_BUSY, 32'd1);
        drain();
        tick(1);
        check_now(0, K_DONE, 32'd1);
        expect_result(0, 5'd16, 8'hFF, 8'hFF, 16'h111F);

        // Reset mid-sweep discards everything; a new sweep then runs normally.
        bus0.query_idx = 4'd0;
        pulse_start(0);
        tick(9);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_now(0, K_BUSY, 32'd0);
        check_now(0, K_DONE, 32'd0);
        check_now(0, K_COUNT, 32'd0);
        check_now(0, K_USEFUL, 32'd0);
        check_now(0, K_SA0, 32'd0);
        check_now(0, K_FVALID, 32'd0);
        drain();
        pulse_start(0);
        tick(32);
        expect_result(0, 5'd16, 8'hFF, 8'hFF, 16'h111F);

        // Stubbed simulator: only net 0 s-a-0, only at pattern 5.
        use_stub = 1'b1;
        pulse_start(0);
        tick(32);
        expect_result(0, 5'd1, 8'h01, 8'h00, 16'h0020);
        expect_query(0, 0, 4'd5, 1'b1);
        for (int i = 1; i < 16; i++) begin
            expect_query(0, i, 4'd0, 1'b0);
        end
        use_stub = 1'b0;

        // Short sweep: PAT_LAST=3, SETTLE=2 finishes after 12 cycles on pattern 3.
        pulse_start(1);
        tick(11);
        expect_v(1, K_DONE, 32'd0);
        expect_v(1, K_BUSY, 32'd1);
        drain();
        tick(1);
        check_now(1, K_DONE, 32'd1);
        expect_v(1, K_PAT, 32'd3);
        expect_result(1, 5'd11, 8'hD9, 8'hF9, 16'h000F);
        expect_query(1, 0, 4'd0, 1'b1);
        expect_query(1, 1, 4'd0, 1'b0);
        expect_query(1, 11, 4'd1, 1'b1);
        expect_query(1, 12, 4'd2, 1'b1);
        expect_query(1, 9, 4'd0, 1'b0);

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
